// File: rtl/mux3_bus_arbiter.sv
// Round-robin owner arbitration for a shared 32-bit 3:1 datapath mux (CPU, VGA reader, debug port).
// Optional forced release of long tenures is built when ARB_TIMEOUT_EN is defined.
module mux3_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Handshake: req is a level held for the whole tenure; done is a one-cycle
  // pulse honoured only from the current owner. grant/sel/timeout are registered,
  // so a request is granted at the edge after it is first seen high.

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t     state, state_n;
  logic [2:0] grant_q, grant_n;
  logic [1:0] sel_q, sel_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] win, nxt;
  logic [2:0] others;
  logic       natural_rel, forced, rel, load;

  // Index of the first set bit of r when scanning p, p+1, p+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] rot;
    logic [2:0] s;
    case (p)
      2'd1:    rot = {r[0], r[2], r[1]};
      2'd2:    rot = {r[1], r[0], r[2]};
      default: rot = r;
    endcase
    if (rot[0])      s = {1'b0, p};
    else if (rot[1]) s = {1'b0, p} + 3'd1;
    else             s = {1'b0, p} + 3'd2;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  assign natural_rel = done[sel_q] | ~req[sel_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  assign forced = (state == OWN) && (cnt == CNT_W'(MAX_HOLD - 1)) && !natural_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forced;
      if (load)
        cnt <= '0;
      else if (state == OWN && !rel && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    sel_n   = sel_q;
    ptr_n   = ptr;
    win     = 2'd0;
    nxt     = 2'd0;
    others  = 3'b000;
    rel     = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        grant_n = 3'b000;
        if (|req) begin
          win     = rr_pick(req, ptr);
          grant_n = onehot(win);
          sel_n   = win;
          load    = 1'b1;
          state_n = OWN;
        end
      end
      OWN: begin
        rel = natural_rel | forced;
        if (rel) begin
          nxt    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          ptr_n  = nxt;
          // The releasing owner is masked out so it cannot win its own release cycle.
          others = req & ~grant_q;
          if (|others) begin
            win     = rr_pick(others, nxt);
            grant_n = onehot(win);
            sel_n   = win;
            load    = 1'b1;
          end else begin
            grant_n = 3'b000;
            state_n = IDLE;
          end
        end
      end
      default: begin
        grant_n = 3'b000;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= 3'b000;
      sel_q   <= 2'd0;
      ptr     <= 2'd0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      sel_q   <= sel_n;
      ptr     <= ptr_n;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// Directed bench for mux3_bus_arbiter: expected {timeout,busy,sel,grant} words are
// queued when each step is driven and compared one cycle later.
module tb_mux3_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mux3_bus_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ex(input logic [2:0] g, input logic [1:0] s, input logic t);
    return {t, |g, s, g};
  endfunction

  task automatic step(input logic r_rst, input logic [2:0] r_req, input logic [2:0] r_done,
                      input logic [6:0] e, input string tag);
    logic [6:0] obs;
    logic [6:0] expv;
    @(negedge clk);
    rst  = r_rst;
    req  = r_req;
    done = r_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs  = {timeout, busy, sel, grant};
    expv = exp_q.pop_front();
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed t/b/sel/grant=%b expected %b", tag, obs, expv);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 3'b000;
    done = 3'b000;

    // Reset, idle, then a single request from requester 1
    step(1'b1, 3'b000, 3'b000, ex(3'b000, 2'd0, 1'b0), "reset_c1");
    step(1'b1, 3'b000, 3'b000, ex(3'b000, 2'd0, 1'b0), "reset_c2");
    step(1'b0, 3'b000, 3'b000, ex(3'b000, 2'd0, 1'b0), "idle_c3");
    step(1'b0, 3'b000, 3'b000, ex(3'b000, 2'd0, 1'b0), "idle_c4");
    step(1'b0, 3'b010, 3'b000, ex(3'b010, 2'd1, 1'b0), "single_grant");
    step(1'b0, 3'b010, 3'b000, ex(3'b010, 2'd1, 1'b0), "single_hold");
    step(1'b0, 3'b000, 3'b000, ex(3'b000, 2'd1, 1'b0), "single_drop_parked");

    // Round robin with all three requesting, done 3 cycles after each grant
    step(1'b1, 3'b000, 3'b000, ex(3'b000, 2'd0, 1'b0), "rr_reset");
    step(1'b0, 3'b111, 3'b000, ex(3'b001, 2'd0, 1'b0), "rr_g0");
    step(1'b0, 3'b111, 3'b000, ex(3'b001, 2'd0, 1'b0), "rr_g0_h1");
    step(1'b0, 3'b111, 3'b000, ex(3'b001, 2'd0, 1'b0), "rr_g0_h2");
    step(1'b0, 3'b111, 3'b001, ex(3'b010, 2'd1, 1'b0), "rr_g1");
    step(1'b0, 3'b111, 3'b000, ex(3'b010, 2'd1, 1'b0), "rr_g1_h1");
    step(1'b0, 3'b111, 3'b000, ex(3'b010, 2'd1, 1'b0), "rr_g1_h2");
    step(1'b0, 3'b111, 3'b010, ex(3'b100, 2'd2, 1'b0), "rr_g2");
    step(1'b0, 3'b111, 3'b000, ex(3'b100, 2'd2, 1'b0), "rr_g2_h1");
    step(1'b0, 3'b111, 3'b000, ex(3'b100, 2'd2, 1'b0), "rr_g2_h2");
    step(1'b0, 3'b111, 3'b100, ex(3'b001, 2'd0, 1'b0), "rr_g0_again");

    // done from non-owners is ignored
    step(1'b0, 3'b111, 3'b010, ex(3'b001, 2'd0, 1'b0), "ignored_done_1");
    step(1'b0, 3'b111, 3'b100, ex(3'b001, 2'd0, 1'b0), "ignored_done_2");

    // Owner 0 drops; pointer at 1 with only 2 pending -> 2 wins, then 2 drops
    step(1'b0, 3'b100, 3'b000, ex(3'b100, 2'd2, 1'b0), "drop_handoff_2");
    step(1'b0, 3'b000, 3'b000, ex(3'b000, 2'd2, 1'b0), "drop_idle");
    step(1'b0, 3'b000, 3'b000, ex(3'b000, 2'd2, 1'b0), "drop_idle_parked");

    // Released owner with its req still high is not re-selected in that cycle
    step(1'b0, 3'b001, 3'b000, ex(3'b001, 2'd0, 1'b0), "solo_grant");
    step(1'b0, 3'b001, 3'b001, ex(3'b000, 2'd0, 1'b0), "solo_done_idle");
    step(1'b0, 3'b001, 3'b000, ex(3'b001, 2'd0, 1'b0), "solo_regrant");

    // Reset mid-tenure with pointer at 1 must restore requester 0 priority
    step(1'b0, 3'b010, 3'b000, ex(3'b010, 2'd1, 1'b0), "mid_handoff_1");
    step(1'b1, 3'b011, 3'b000, ex(3'b000, 2'd0, 1'b0), "mid_reset");
    step(1'b0, 3'b011, 3'b000, ex(3'b001, 2'd0, 1'b0), "mid_after_reset_p0");

    // Owner 0 never signals done with requester 2 waiting
    step(1'b1, 3'b000, 3'b000, ex(3'b000, 2'd0, 1'b0), "to_reset");
    step(1'b0, 3'b101, 3'b000, ex(3'b001, 2'd0, 1'b0), "to_grant0");
`ifdef ARB_TIMEOUT_EN
    step(1'b0, 3'b101, 3'b000, ex(3'b001, 2'd0, 1'b0), "to_hold1");
    step(1'b0, 3'b101, 3'b000, ex(3'b001, 2'd0, 1'b0), "to_hold2");
    step(1'b0, 3'b101, 3'b000, ex(3'b001, 2'd0, 1'b0), "to_hold3");
    step(1'b0, 3'b101, 3'b000, ex(3'b100, 2'd2, 1'b1), "to_evict");
    step(1'b0, 3'b101, 3'b000, ex(3'b100, 2'd2, 1'b0), "to_pulse_end");
`else
    for (int i = 0; i < 100; i++)
      step(1'b0, 3'b101, 3'b000, ex(3'b001, 2'd0, 1'b0), "no_timeout_hold");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux3_bus_arbiter.md
Name: mux3_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit 3:1 datapath mux between three requesters: 0 = CPU data port, 1 = VGA/framebuffer reader, 2 = debug/input port.
- Produces the registered 2-bit mux select and a one-hot grant.
- Requesters hold a tenure until they signal done or drop their request.
- Sits between the requesters and the shared mux. `sel` connects directly to the mux select input.

Parameters:
- MAX_HOLD, 16: maximum tenure in cycles before a forced release. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..(2^CNT_W − 1).
- CNT_W, 5: width of the tenure counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  3  request per requester; bit i = requester i. Level-sensitive.
- done  input  3  one-cycle pulse from the current owner ending its tenure. Ignored from non-owners.
- grant  output  3  one-hot grant, registered; all-zero when no owner.
- sel  output  2  registered mux select: 2'b00, 2'b01 or 2'b10 only. Never 2'b11.
- busy  output  1  high while any grant is active (equals |grant).
- timeout  output  1  one-cycle pulse when a tenure is force-ended. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - grant=3'b000, sel=2'b00, busy=0, timeout=0.
  - Priority pointer = 0, so requester 0 is highest after reset.
  - Tenure counter = 0, state = IDLE.
  - Reset mid-tenure drops the grant on the same edge, without any done handshake.
- States: IDLE (no owner) and OWN (one owner).
- Arbitration order: start at pointer p and scan p, p+1, p+2 (mod 3); the first requester with req high wins.
- IDLE:
  - If req != 0, the winner is granted at the next edge: grant one-hot, sel = winner index, busy=1, counter=0, go to OWN.
  - Latency from req rising to grant high: exactly 1 cycle.
  - If req == 0, stay in IDLE; grant=0; sel holds its last value (parked, not reset to 0).
- OWN, release condition = done[owner] OR !req[owner] (OR timeout, when enabled):
  - On release, pointer becomes (owner+1) mod 3.
  - If another requester is pending, it is granted at the same edge: back-to-back hand-off, no idle cycle, grant moves directly from one bit to another.
  - The released owner is never re-selected in the release cycle, even if its req is still high.
  - If no other requester is pending, go to IDLE at that edge.
- No release: grant and sel are stable and the counter increments (saturating at 2^CNT_W − 1).
- Simultaneous events:
  - done[owner] in the same cycle as new requests behaves as a normal release with round-robin selection.
  - done bits from non-owners are ignored.
- Invariants:
  - grant is always one-hot or zero.
  - sel equals the index of the set grant bit whenever busy=1.
  - sel is never 2'b11.
- No combinational path from req or done to any output.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In OWN, when counter == MAX_HOLD−1 and no other release condition holds, the tenure is force-released at the next edge.
  - timeout pulses high for exactly 1 cycle, coincident with the grant change.
  - Pointer advance and hand-off follow the normal release rules.
  - The evicted requester must re-request; its req staying high makes it eligible in later arbitration, but not in the eviction cycle.
- Undefined: the counter logic is not generated; timeout is constant 0; tenure is unbounded.

Test Plan:
- Reset then single request:
  - Stimulus: rst high 2 cycles; req=3'b010 at cycle 5.
  - Required: grant=3'b010 and sel=2'b01 at cycle 6; busy=1. Before cycle 6, grant=0 and sel=2'b00.
- Round-robin rotation:
  - Stimulus: req=3'b111 held constantly; each owner pulses done 3 cycles after its grant.
  - Required: grant order 001, 010, 100, 001; hand-offs have no idle cycle between grants.
- Request drop:
  - Stimulus: owner 2 deasserts req with req=3'b000 otherwise.
  - Required: next cycle grant=0, busy=0, sel stays 2'b10.
- Ignored done:
  - Stimulus: owner 0 holds; done=3'b010 is pulsed.
  - Required: grant stays 3'b001.
- Reset mid-tenure:
  - Stimulus: owner 1 active; rst pulsed for 1 cycle.
  - Required: next cycle grant=0, sel=00, pointer=0. With req=3'b011 afterwards, requester 0 wins.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):
  - Stimulus: req=3'b101 held; owner 0 never pulses done.
  - Required: 4 cycles after its grant, timeout=1 for 1 cycle and grant=3'b100. Without the macro, grant=3'b001 persists for 100 cycles and timeout stays 0.
